// File: rtl/bpu_pht_upd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bpu_pht_upd_ctrl
//  Description : Port sequencer for the 2-bit pattern history table. Fetch
//                lookups and queued branch-resolution updates share the
//                single PHT read port. Updates perform a read-modify-write of
//                the saturating counter through a one-entry write stage (S1),
//                with forwarding for back-to-back updates to one index. A
//                starvation guard lets a waiting update steal a read slot
//                from lookups. A clear FSM sweeps the whole table to 2'b00.
//  Ports       :
//    clk, rst_n                  clock, asynchronous active-low reset
//    i_lkp_vld/i_lkp_idx         fetch lookup request
//    o_lkp_rdy/o_lkp_cnt         lookup serviced / counter read for it
//    i_upd_vld/i_upd_idx/
//    i_upd_taken/o_upd_rdy       update request handshake
//    i_clr_req/o_clr_busy        full-table clear request / sweep active
//    o_pht_ridx/i_pht_rd_entry   PHT read port (data combinational)
//    o_pht_wren/o_pht_widx/
//    o_pht_wr_entry              PHT write port
//  Revision    : 1.0 - initial release
// ============================================================================
module bpu_pht_upd_ctrl #(
    parameter int IDX_W      = 11,
    parameter int PHT_DEPTH  = 2048,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_lkp_vld,
    input  logic [IDX_W-1:0] i_lkp_idx,
    output logic             o_lkp_rdy,
    output logic [1:0]       o_lkp_cnt,
    input  logic             i_upd_vld,
    output logic             o_upd_rdy,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken,
    input  logic             i_clr_req,
    output logic             o_clr_busy,
    output logic [IDX_W-1:0] o_pht_ridx,
    input  logic [1:0]       i_pht_rd_entry,
    output logic             o_pht_wren,
    output logic [IDX_W-1:0] o_pht_widx,
    output logic [1:0]       o_pht_wr_entry
);

    localparam int C_PTR_W = $clog2(FIFO_DEPTH);
    localparam int C_STV_W = $clog2(STARVE_LIM + 1);

    localparam logic [C_PTR_W:0]   C_PTR_ONE  = (C_PTR_W + 1)'(1);
    localparam logic [C_STV_W-1:0] C_STV_MAX  = C_STV_W'(STARVE_LIM);
    localparam logic [C_STV_W-1:0] C_STV_ONE  = C_STV_W'(1);
    localparam logic [IDX_W-1:0]   C_IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]   C_CLR_LAST = IDX_W'(PHT_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_NORM  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Update queue storage; pointers carry one extra wrap bit for full/empty.
    logic [IDX_W-1:0]      r_fifo_idx [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_tkn;
    logic [C_PTR_W:0]      r_wptr;
    logic [C_PTR_W:0]      r_rptr;

    logic [C_STV_W-1:0]    r_starve;
    logic                  r_s1_vld;
    logic [IDX_W-1:0]      r_s1_idx;
    logic [1:0]            r_s1_cnt;
    logic [IDX_W-1:0]      r_clr_idx;

    logic                  w_empty;
    logic                  w_full;
    logic [IDX_W-1:0]      w_head_idx;
    logic                  w_head_tkn;
    logic                  w_steal;
    logic                  w_gnt;
    logic                  w_push;
    logic                  w_flush;
    logic [1:0]            w_old;
    logic [1:0]            w_new;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[C_PTR_W] != r_rptr[C_PTR_W]) &&
                        (r_wptr[C_PTR_W-1:0] == r_rptr[C_PTR_W-1:0]);
    assign w_head_idx = r_fifo_idx[r_rptr[C_PTR_W-1:0]];
    assign w_head_tkn = r_fifo_tkn[r_rptr[C_PTR_W-1:0]];
    assign w_steal    = (r_starve == C_STV_MAX) && !w_empty;
    assign w_push     = i_upd_vld && o_upd_rdy;

    assign o_lkp_cnt  = i_pht_rd_entry;
    assign o_pht_ridx = w_gnt ? w_head_idx : i_lkp_idx;

    // The counter still sitting in S1 has not reached the table yet, so an
    // update to the same index must build on it rather than on the stale read.
    always_comb begin
        w_old = (r_s1_vld && (r_s1_idx == w_head_idx)) ? r_s1_cnt : i_pht_rd_entry;
        if (w_head_tkn) begin
            w_new = (w_old == 2'b11) ? 2'b11 : (w_old + 2'b01);
        end else begin
            w_new = (w_old == 2'b00) ? 2'b00 : (w_old - 2'b01);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_NORM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, arbitration and port outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_gnt          = 1'b0;
        w_flush        = 1'b0;
        o_lkp_rdy      = 1'b1;
        o_upd_rdy      = 1'b0;
        o_clr_busy     = 1'b0;
        o_pht_wren     = r_s1_vld;
        o_pht_widx     = r_s1_idx;
        o_pht_wr_entry = r_s1_cnt;
        case (r_state)
            ST_NORM: begin
                w_gnt     = !w_empty && !i_clr_req && (!i_lkp_vld || w_steal);
                o_lkp_rdy = !(w_steal && !i_clr_req);
                o_upd_rdy = !w_full && !i_clr_req;
                if (i_clr_req) begin
                    // Queued updates are dropped; a pending S1 write still
                    // goes out this cycle through the default write port.
                    w_flush     = 1'b1;
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                o_clr_busy     = 1'b1;
                o_pht_wren     = 1'b1;
                o_pht_widx     = r_clr_idx;
                o_pht_wr_entry = 2'b00;
                if (r_clr_idx == C_CLR_LAST) begin
                    w_state_nxt = ST_NORM;
                end
            end
            default: begin
                w_state_nxt = ST_NORM;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Queue storage (no reset needed: guarded by the pointers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_idx[r_wptr[C_PTR_W-1:0]] <= i_upd_idx;
            r_fifo_tkn[r_wptr[C_PTR_W-1:0]] <= i_upd_taken;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, starvation counter, S1 stage and clear sweep index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_starve  <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_idx  <= '0;
            r_s1_cnt  <= 2'b00;
            r_clr_idx <= '0;
        end else begin
            if (w_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + C_PTR_ONE;
                end
                if (w_gnt) begin
                    r_rptr <= r_rptr + C_PTR_ONE;
                end
            end

            if ((r_state != ST_NORM) || w_flush || w_gnt || w_empty) begin
                r_starve <= '0;
            end else if (i_lkp_vld && (r_starve != C_STV_MAX)) begin
                r_starve <= r_starve + C_STV_ONE;
            end

            r_s1_vld <= w_gnt;
            if (w_gnt) begin
                r_s1_idx <= w_head_idx;
                r_s1_cnt <= w_new;
            end

            if (w_flush) begin
                r_clr_idx <= '0;
            end else if (r_state == ST_CLEAR) begin
                r_clr_idx <= r_clr_idx + C_IDX_ONE;
            end
        end
    end

endmodule
`default_nettype wire
